muxn_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output. It supersedes the combinational 2:1 mux. It adds channel count and data width generics, a one-cycle output register, and two selection modes: external select, or fair round-robin arbitration. It sits between multiple producer blocks and a single consumer datapath.

---
 rtl/muxn_rr.sv | 136 +++++++++++++
 tb/tb_muxn_rr.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_rr.sv
// N-channel registered multiplexer with valid/ready handshakes on every port.
// Channel choice comes from an external select or a fair round-robin arbiter.
module muxn_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned NCHU = NCH;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic             load;
    logic             xfer;
    logic             gnt_v;
    logic [SELW-1:0]  gnt;
    logic [WIDTH-1:0] gnt_data;

    assign load = !out_valid_q || out_ready;
    // Gated by rst_n so no channel sees an accept while reset is held.
    assign xfer = load && gnt_v && rst_n;

    generate
        if (MODE == 0) begin : g_ext_sel
            always_comb begin
                gnt   = sel;
                gnt_v = 1'b0;
                for (int unsigned k = 0; k < NCHU; k++) begin
                    if (sel == SELW'(k)) begin
                        gnt_v = in_valid[k];
                    end
                end
            end
        end else begin : g_round_robin
            logic [SELW-1:0] last_q, last_d;
            int unsigned     cand;
            logic            unused_sel;

            assign unused_sel = ^sel;

            // Visit channels starting just after the last winner; first valid one wins.
            always_comb begin
                gnt   = '0;
                gnt_v = 1'b0;
                cand  = 0;
                for (int unsigned off = 1; off <= NCHU; off++) begin
                    cand = 32'(last_q) + off;
                    if (cand >= NCHU) begin
                        cand = cand - NCHU;
                    end
                    for (int unsigned k = 0; k < NCHU; k++) begin
                        if (!gnt_v && (cand == k) && in_valid[k]) begin
                            gnt   = SELW'(k);
                            gnt_v = 1'b1;
                        end
                    end
                end
            end

            always_comb begin
                last_d = last_q;
                if (xfer) begin
                    last_d = gnt;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    last_q <= SELW'(NCH - 1);
                end else begin
                    last_q <= last_d;
                end
            end
        end
    endgenerate

    always_comb begin
        gnt_data = '0;
        for (int unsigned k = 0; k < NCHU; k++) begin
            if (gnt == SELW'(k)) begin
                gnt_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned k = 0; k < NCHU; k++) begin
            in_ready[k] = xfer && (gnt == SELW'(k));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = gnt_v;
            if (gnt_v) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Bench for muxn_rr: one round-robin and one external-select instance,
// checked every cycle against a transaction-level model plus directed literals.
module tb_muxn_rr;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*W-1:0] rr_data, es_data;
    logic [N-1:0]   rr_valid, es_valid, rr_ready, es_ready;
    logic [SW-1:0]  rr_sel, es_sel, rr_och, es_och;
    logic [W-1:0]   rr_odata, es_odata;
    logic           rr_ovalid, es_ovalid, rr_oready, es_oready;

    int n_chk = 0;
    int n_fail = 0;

    muxn_rr #(.WIDTH(W), .NCH(N), .SELW(SW), .MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_data(rr_data), .in_valid(rr_valid), .in_ready(rr_ready),
        .sel(rr_sel),
        .out_data(rr_odata), .out_ch(rr_och), .out_valid(rr_ovalid),
        .out_ready(rr_oready)
    );

    muxn_rr #(.WIDTH(W), .NCH(N), .SELW(SW), .MODE(0)) dut_es (
        .clk(clk), .rst_n(rst_n),
        .in_data(es_data), .in_valid(es_valid), .in_ready(es_ready),
        .sel(es_sel),
        .out_data(es_odata), .out_ch(es_och), .out_valid(es_ovalid),
        .out_ready(es_oready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = external select, index 1 = round robin.
    typedef struct {
        bit          ov;
        logic [W-1:0] od;
        int          och;
        int          last;
    } mstate_t;
    mstate_t m[2];

    function automatic void grant(input int mode, input int last, input logic [N-1:0] v,
                                  input logic [SW-1:0] s, output int g, output bit gv);
        g  = 0;
        gv = 1'b0;
        if (mode == 0) begin
            g  = int'(s);
            gv = (g < N) && v[g];
        end else begin
            for (int off = 1; off <= N; off++) begin
                int k;
                k = (last + off) % N;
                if (!gv && v[k]) begin
                    g  = k;
                    gv = 1'b1;
                end
            end
        end
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m[i].ov   = 1'b0;
            m[i].od   = '0;
            m[i].och  = 0;
            m[i].last = N - 1;
        end
    endtask

    task automatic mstep(input int i, input logic [N*W-1:0] d, input logic [N-1:0] v,
                         input logic [SW-1:0] s, input logic ordy);
        int g;
        bit gv;
        if (m[i].ov && !ordy) return;
        grant(i, m[i].last, v, s, g, gv);
        if (gv) begin
            m[i].ov  = 1'b1;
            m[i].od  = d[g*W +: W];
            m[i].och = g;
            if (i == 1) m[i].last = g;
        end else begin
            m[i].ov = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset();
        end else begin
            mstep(0, es_data, es_valid, es_sel, es_oready);
            mstep(1, rr_data, rr_valid, rr_sel, rr_oready);
        end
    end

    task automatic cmp(input int i, input logic ov, input logic [W-1:0] od,
                       input logic [SW-1:0] och, input logic [N-1:0] rdy,
                       input logic [N-1:0] v, input logic [SW-1:0] s, input logic ordy);
        int g;
        bit gv;
        logic [N-1:0] er;
        er = '0;
        grant(i, m[i].last, v, s, g, gv);
        if (rst_n && (!m[i].ov || ordy) && gv) er[g] = 1'b1;
        chk(i == 1 ? "rr_model_valid" : "es_model_valid", 32'(ov), 32'(m[i].ov));
        chk(i == 1 ? "rr_model_data" : "es_model_data", 32'(od), 32'(m[i].od));
        chk(i == 1 ? "rr_model_ch" : "es_model_ch", 32'(och), m[i].och);
        chk(i == 1 ? "rr_model_ready" : "es_model_ready", 32'(rdy), 32'(er));
    endtask

    always @(negedge clk) begin
        cmp(0, es_ovalid, es_odata, es_och, es_ready, es_valid, es_sel, es_oready);
        cmp(1, rr_ovalid, rr_odata, rr_och, rr_ready, rr_valid, rr_sel, rr_oready);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ws[4];
        ws = '{2, 1, 2, 1};
        mreset();
        rr_valid = '1; es_valid = '1;
        rr_oready = 1'b1; es_oready = 1'b1;
        rr_sel = '0; es_sel = '0;
        for (int k = 0; k < N; k++) begin
            rr_data[k*W +: W] = 8'hA0 + 8'(k);
            es_data[k*W +: W] = 8'hB0 + 8'(k);
        end

        // Reset held with every channel requesting
        repeat (3) cyc();
        #2;
        chk("rst_out_valid", 32'(rr_ovalid), 0);
        chk("rst_out_data", 32'(rr_odata), 0);
        chk("rst_out_ch", 32'(rr_och), 0);
        chk("rst_rr_ready", 32'(rr_ready), 0);
        chk("rst_es_ready", 32'(es_ready), 0);

        cyc();
        rst_n = 1'b1;
        #2;
        chk("rr_first_grant", 32'(rr_ready), 32'h1);

        // Fairness: A0 A1 A2 A3 A0 ...
        for (int i = 0; i < 8; i++) begin
            cyc(); #2;
            chk("rr_seq_data", 32'(rr_odata), 32'hA0 + 32'(i % 4));
            chk("rr_seq_ch", 32'(rr_och), 32'(i % 4));
        end

        // Stall holding 55
        rr_data[0 +: W] = 8'h55;
        cyc();
        rr_oready = 1'b0;
        #2;
        chk("stall_data", 32'(rr_odata), 32'h55);
        chk("stall_ready", 32'(rr_ready), 0);
        rr_data[0 +: W] = 8'hA0;
        repeat (3) begin
            cyc(); #2;
            chk("stall_hold_data", 32'(rr_odata), 32'h55);
            chk("stall_hold_valid", 32'(rr_ovalid), 1);
            chk("stall_hold_ready", 32'(rr_ready), 0);
        end
        rr_oready = 1'b1;
        #1;
        chk("unstall_ready", 32'(rr_ready), 32'h2);
        cyc(); #2;
        chk("unstall_data", 32'(rr_odata), 32'hA1);

        // Wrap and skip with only channels 1 and 2 requesting
        rr_valid = 4'b0110;
        #1;
        chk("skip_ready", 32'(rr_ready), 32'h4);
        for (int i = 0; i < 4; i++) begin
            cyc(); #2;
            chk("skip_ch", 32'(rr_och), 32'(ws[i]));
            chk("skip_data", 32'(rr_odata), 32'hA0 + 32'(ws[i]));
        end

        // Idle cycles do not rotate priority
        rr_valid = '0;
        cyc(); #2;
        chk("idle_valid", 32'(rr_ovalid), 0);
        chk("idle_hold_ch", 32'(rr_och), 1);
        chk("idle_hold_data", 32'(rr_odata), 32'hA1);
        cyc();
        rr_valid = '1;
        #1;
        chk("idle_no_rotate", 32'(rr_ready), 32'h4);

        // Asynchronous reset between edges
        cyc(); cyc();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rr_ovalid), 0);
        chk("arst_data", 32'(rr_odata), 0);
        chk("arst_ready", 32'(rr_ready), 0);
        cyc();
        rst_n = 1'b1;
        #2;
        chk("arst_restart_ready", 32'(rr_ready), 32'h1);
        cyc(); #2;
        chk("arst_restart_data", 32'(rr_odata), 32'hA0);
        chk("arst_restart_ch", 32'(rr_och), 0);

        // External select
        es_sel = 2'd3;
        es_valid = 4'b1000;
        es_data[3*W +: W] = 8'h3C;
        #1;
        chk("es_ready_sel3", 32'(es_ready), 32'h8);
        cyc(); #2;
        chk("es_data_sel3", 32'(es_odata), 32'h3C);
        chk("es_ch_sel3", 32'(es_och), 3);
        chk("es_valid_sel3", 32'(es_ovalid), 1);
        es_sel = 2'd1;
        #1;
        chk("es_ready_sel1_idle", 32'(es_ready), 0);
        cyc(); #2;
        chk("es_valid_drop", 32'(es_ovalid), 0);
        chk("es_hold_data", 32'(es_odata), 32'h3C);
        chk("es_hold_ch", 32'(es_och), 3);

        es_sel = 2'd3;
        cyc();
        es_oready = 1'b0;
        es_sel = 2'd0;
        es_valid = '1;
        #1;
        chk("es_stall_ready", 32'(es_ready), 0);
        cyc(); #2;
        chk("es_stall_data", 32'(es_odata), 32'h3C);
        chk("es_stall_valid", 32'(es_ovalid), 1);
        es_oready = 1'b1;
        #1;
        chk("es_unstall_ready", 32'(es_ready), 32'h1);
        cyc(); #2;
        chk("es_unstall_data", 32'(es_odata), 32'hB0);
        chk("es_unstall_ch", 32'(es_och), 0);

        // Mixed traffic, checked by the model only
        repeat (60) begin
            cyc();
            rr_valid  = N'($urandom_range(0, 15));
            es_valid  = N'($urandom_range(0, 15));
            es_sel    = SW'($urandom_range(0, 3));
            rr_oready = ($urandom_range(0, 3) != 0);
            es_oready = ($urandom_range(0, 3) != 0);
            rr_data   = $urandom;
            es_data   = $urandom;
        end
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
